// File: rtl/fcvt_wb.sv
// Writeback stage for the convert units: elastic result queue, sticky fflags, register-hit query.
// Define FCVT_WB_SKID_EN for a 2-entry skid queue with registered in_ready; default is a single stage.
module fcvt_wb #(
  parameter int F_WIDTH = 32,
  parameter int R_WIDTH = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [R_WIDTH-1:0] in_rd,
  input  logic [F_WIDTH-1:0] in_data,
  input  logic [4:0]         in_fflags,
  input  logic               flush,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [R_WIDTH-1:0] wb_rd,
  output logic [F_WIDTH-1:0] wb_data,
  input  logic               csr_we,
  input  logic [4:0]         csr_wdata,
  output logic [4:0]         fflags,
  input  logic [R_WIDTH-1:0] chk_rd,
  output logic               chk_hit
);

`ifdef FCVT_WB_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic [R_WIDTH-1:0] rd_q   [DEPTH];
  logic [R_WIDTH-1:0] rd_d   [DEPTH];
  logic [F_WIDTH-1:0] data_q [DEPTH];
  logic [F_WIDTH-1:0] data_d [DEPTH];
  logic [4:0]         ff_q   [DEPTH];
  logic [4:0]         ff_d   [DEPTH];
  logic [1:0]         count_q, count_d;
  logic [1:0]         wr_idx;
  logic [4:0]         fflags_q, fflags_d;
  logic               accept, retire;
  logic [DEPTH-1:0]   hit_vec;

  assign wb_valid = (count_q != 2'd0);
  assign wb_rd    = rd_q[0];
  assign wb_data  = data_q[0];
  assign fflags   = fflags_q;
  assign retire   = wb_valid & wb_ready;
  assign accept   = in_valid & in_ready;
  // Slot 0 is the head; a retire shifts everything down, so the write slot follows.
  assign wr_idx   = count_q - {1'b0, retire};

`ifdef FCVT_WB_SKID_EN
  logic in_ready_q, in_ready_d;
  assign in_ready   = in_ready_q;
  assign in_ready_d = (count_d < 2'd2);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) in_ready_q <= 1'b1;
    else     in_ready_q <= in_ready_d;
  end
`else
  assign in_ready = ~wb_valid | wb_ready;
`endif

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rd_d[i]   = rd_q[i];
      data_d[i] = data_q[i];
      ff_d[i]   = ff_q[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (retire) begin
        rd_d[i]   = rd_q[i+1];
        data_d[i] = data_q[i+1];
        ff_d[i]   = ff_q[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && !flush && wr_idx == 2'(i)) begin
        rd_d[i]   = in_rd;
        data_d[i] = in_data;
        ff_d[i]   = in_fflags;
      end
    end

    count_d = count_q;
    case ({accept, retire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (flush) count_d = 2'd0;

    // A retire that coincides with flush has already written the register file.
    fflags_d = (csr_we ? csr_wdata : fflags_q) | (retire ? ff_q[0] : 5'd0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q  <= 2'd0;
      fflags_q <= 5'd0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
        ff_q[i]   <= '0;
      end
    end else begin
      count_q  <= count_d;
      fflags_q <= fflags_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
        ff_q[i]   <= ff_d[i];
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign hit_vec[gi] = (count_q > 2'(gi)) && (rd_q[gi] == chk_rd);
  end
  assign chk_hit = |hit_vec;

endmodule

// File: tb/tb_fcvt_wb.sv
// Scoreboard bench for fcvt_wb: stimulus pushes expected results, a negedge monitor pops on retire.
module tb_fcvt_wb;
`ifdef FCVT_WB_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_fflags = '0;
  logic        flush = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        csr_we = 1'b0;
  logic [4:0]  csr_wdata = '0;
  logic [4:0]  fflags;
  logic [4:0]  chk_rd = '0;
  logic        chk_hit;

  int checks = 0;
  int failures = 0;
  logic [36:0] sb[$];

  fcvt_wb #(.F_WIDTH(32), .R_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data), .in_fflags(in_fflags),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .csr_we(csr_we), .csr_wdata(csr_wdata), .fflags(fflags),
    .chk_rd(chk_rd), .chk_hit(chk_hit)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a retire happens at the next posedge when valid & ready are seen here.
  always @(negedge CLK) begin
    if (!RST) begin
      if (wb_valid && wb_ready) begin
        if (sb.size() == 0) begin
          check("retire_unexpected", {27'd0, wb_rd}, 32'hFFFF_FFFF);
        end else begin
          logic [36:0] e;
          e = sb.pop_front();
          $display("retire rd=%0d data=0x%08h (expect rd=%0d data=0x%08h)", wb_rd, wb_data, e[36:32], e[31:0]);
          check("retire_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
          check("retire_data", wb_data, e[31:0]);
        end
      end
      if (flush) sb.delete();
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [4:0] rd, input logic [31:0] d, input logic [4:0] ff);
    int n;
    n = 0;
    in_valid = 1'b1; in_rd = rd; in_data = d; in_fflags = ff;
    @(negedge CLK);
    while (!in_ready && n < 40) begin
      @(posedge CLK); #1; @(negedge CLK); n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    else sb.push_back({rd, d});
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  logic [4:0] bp_rd [3];

  initial begin
    int idx, acc, n;
    bp_rd[0] = 5'd1; bp_rd[1] = 5'd2; bp_rd[2] = 5'd3;

    // Reset values
    step(); step();
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_fflags", {27'd0, fflags}, 32'd0);
    check("rst_chk_hit", {31'd0, chk_hit}, 32'd0);
    RST = 1'b0;
    step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single result
    wb_ready = 1'b1;
    send(5'd3, 32'h3F80_0000, 5'h00);
    check("single_valid", {31'd0, wb_valid}, 32'd1);
    check("single_rd", {27'd0, wb_rd}, 32'd3);
    check("single_data", wb_data, 32'h3F80_0000);
    step();
    check("single_fflags", {27'd0, fflags}, 32'd0);
    check("single_drained", {31'd0, wb_valid}, 32'd0);

    // NX accumulation and CSR priority
    send(5'd5, 32'h4B80_0000, 5'h01);
    step();
    check("nx_fflags", {27'd0, fflags}, 32'h01);
    send(5'd6, 32'h4B00_0000, 5'h01);
    csr_we = 1'b1; csr_wdata = 5'h00;
    step();
    csr_we = 1'b0;
    check("csr_with_retire", {27'd0, fflags}, 32'h01);
    csr_we = 1'b1; csr_wdata = 5'h00;
    step();
    csr_we = 1'b0;
    check("csr_alone", {27'd0, fflags}, 32'h00);

    // Back-pressure: offer rd=1,2,3 with wb_ready low
    wb_ready = 1'b0;
    idx = 0; acc = 0;
    in_valid = 1'b1; in_rd = bp_rd[0]; in_data = 32'h1000_0001; in_fflags = 5'h00;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (in_ready && idx < 3) begin
        sb.push_back({in_rd, in_data}); idx++; acc++;
      end
      @(posedge CLK); #1;
      if (idx < 3) begin
        in_rd = bp_rd[idx]; in_data = 32'h1000_0001 + 32'(idx);
      end else in_valid = 1'b0;
    end
    check("bp_accepted", acc, DEPTH);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_head_stable", {27'd0, wb_rd}, 32'd1);
    wb_ready = 1'b1;
    n = 0;
    while (idx < 3 && n < 20) begin
      @(negedge CLK);
      if (in_ready) begin
        sb.push_back({in_rd, in_data}); idx++;
      end
      @(posedge CLK); #1;
      if (idx < 3) begin
        in_rd = bp_rd[idx]; in_data = 32'h1000_0001 + 32'(idx);
      end else in_valid = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    check("bp_all_offered", idx, 3);
    n = 0;
    while (wb_valid && n < 20) begin step(); n++; end
    check("bp_drained", {31'd0, wb_valid}, 32'd0);
    check("bp_sb_empty", sb.size(), 0);

    // Flush with a full queue and no retire
    wb_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) send(5'(20 + k), 32'hAAAA_0000 + 32'(k), 5'h01);
    check("flush_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", {31'd0, wb_valid}, 32'd0);
    check("flush_fflags", {27'd0, fflags}, 32'h00);

    // Flush coincident with a retire and an offer
    send(5'd9, 32'h4000_0000, 5'h04);
    if (DEPTH > 1) send(5'd10, 32'h4040_0000, 5'h02);
    wb_ready = 1'b1; flush = 1'b1;
    in_valid = 1'b1; in_rd = 5'd11; in_data = 32'h4080_0000; in_fflags = 5'h08;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_retire_valid", {31'd0, wb_valid}, 32'd0);
    check("flush_retire_fflags", {27'd0, fflags}, 32'h04);
    step();
    check("flush_retire_fflags_hold", {27'd0, fflags}, 32'h04);
    csr_we = 1'b1; csr_wdata = 5'h00;
    step();
    csr_we = 1'b0;

    // Hazard query
    wb_ready = 1'b0; chk_rd = 5'd7;
    step();
    check("hit_empty", {31'd0, chk_hit}, 32'd0);
    send(5'd7, 32'h40A0_0000, 5'h00);
    check("hit_buffered", {31'd0, chk_hit}, 32'd1);
    chk_rd = 5'd8; #1;
    check("hit_other_rd", {31'd0, chk_hit}, 32'd0);
    chk_rd = 5'd7; wb_ready = 1'b1;
    step();
    check("hit_after_retire", {31'd0, chk_hit}, 32'd0);

    // Async reset mid-cycle with entries queued and fflags=0x01
    send(5'd12, 32'h40C0_0000, 5'h01);
    step();
    check("pre_reset_fflags", {27'd0, fflags}, 32'h01);
    wb_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) send(5'(13 + k), 32'h4100_0000 + 32'(k), 5'h02);
    chk_rd = 5'd13;
    #2 RST = 1'b1;
    #1;
    check("areset_valid", {31'd0, wb_valid}, 32'd0);
    check("areset_fflags", {27'd0, fflags}, 32'h00);
    check("areset_chk_hit", {31'd0, chk_hit}, 32'd0);
    sb.delete();
    step();
    RST = 1'b0;
    step();
    check("areset_in_ready", {31'd0, in_ready}, 32'd1);
    check("areset_fflags_after", {27'd0, fflags}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
